shift_reg_ctrl: RTL and testbench

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

---
 rtl/shift_reg_ctrl_pkg.sv | 24 ++
 rtl/shift_reg_ctrl_cnt.sv | 53 +++++
 rtl/shift_reg_ctrl.sv | 160 ++++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl_pkg
//
// Shared definitions for the shift register controller slice.
//
// Contents:
//   DEFAULT_WIDTH - default word width in bits for the controller and counter
//   state_t       - controller FSM state encoding (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package shift_reg_ctrl_pkg;

    // Default word width used by every module of the slice.
    localparam int DEFAULT_WIDTH = 32;

    // IDLE  : waiting for a transmit word, external register tracks tx_data
    // SHIFT : one bit leaves on ser_out and one enters from ser_in per edge
    // DONE  : received word presented on rx_data until the consumer takes it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_reg_ctrl_pkg

// File: rtl/shift_reg_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl_cnt
//
// Shift counter for shift_reg_ctrl. Counts shift edges within one word and
// flags the last one. The count is $clog2(WIDTH) bits wide, so for a power-of-
// two WIDTH it would wrap one edge after the terminal count; the controller
// always leaves SHIFT on the terminal-count edge, so the wrap is never seen.
//
// Parameters:
//   WIDTH  - word width in bits (>= 2)
//
// Ports:
//   clk    in   clock, rising edge active
//   rst_n  in   asynchronous active-low reset, clears the count
//   clear  in   synchronous clear to 0 (word accepted)
//   inc    in   increment by one (one shift edge)
//   tc     out  terminal count: count equals WIDTH-1
// -----------------------------------------------------------------------------
module shift_reg_ctrl_cnt
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Count register: clear has priority so an accept always restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

    // Terminal count marks the final shift edge of the word.
    always_comb begin
        tc = (count == LAST);
    end

endmodule : shift_reg_ctrl_cnt

// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//
// Controller for an external parallel/serial ShiftReg. A transmit word is
// parallel-loaded into the ShiftReg, shifted out on ser_out (MSB first) for
// exactly WIDTH edges while ser_in is shifted into the LSB, and the resulting
// contents are then offered as the received word. The register is held by
// reloading its own contents while the received word waits.
//
// Configuration macro:
//   SHIFT_REG_CTRL_LSB_FIRST_EN - when defined, the transmit word is bit-
//     reversed on load and the received word is bit-reversed on output,
//     giving LSB-first transmission and reception. The DONE hold path is
//     never reversed.
//
// Parameters:
//   WIDTH       - word width in bits (>= 2)
//
// Ports:
//   clk         in   clock, rising edge active
//   rst_n       in   asynchronous active-low reset
//   tx_valid    in   transmit word offered
//   tx_ready    out  controller accepts a transmit word (IDLE, out of reset)
//   tx_data     in   transmit word
//   rx_valid    out  received word available (DONE)
//   rx_ready    in   consumer takes the received word
//   rx_data     out  received word (0 outside DONE)
//   ser_in      in   external serial input line
//   ser_out     out  external serial output line
//   ser_frame   out  high while bits are being shifted
//   sr_srl_prl  out  ShiftReg mode: 1 = shift one bit, 0 = parallel load
//   sr_srl_in   out  ShiftReg serial input (enters at the LSB)
//   sr_prl_in   out  ShiftReg parallel load value
//   sr_srl_out  in   ShiftReg MSB
//   sr_prl_out  in   ShiftReg contents
// -----------------------------------------------------------------------------
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             sr_srl_prl,
    output logic             sr_srl_in,
    output logic [WIDTH-1:0] sr_prl_in,
    input  logic             sr_srl_out,
    input  logic [WIDTH-1:0] sr_prl_out
);

    state_t state;
    state_t state_next;

    logic cnt_clear;
    logic cnt_inc;
    logic cnt_tc;

    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] recv_word;

    shift_reg_ctrl_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

`ifdef SHIFT_REG_CTRL_LSB_FIRST_EN
    // Reversing on load puts the LSB at the ShiftReg MSB, so it leaves first;
    // reversing on output undoes the order the bits arrived in.
    always_comb begin
        load_word = '0;
        recv_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_word[i] = tx_data[WIDTH-1-i];
            recv_word[i] = sr_prl_out[WIDTH-1-i];
        end
    end
`else
    always_comb begin
        load_word = tx_data;
        recv_word = sr_prl_out;
    end
`endif

    // State register; reset discards any partial or pending word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. tx_ready is qualified with rst_n so it
    // stays low while reset is held even though the state already reads IDLE.
    // Outside IDLE the ShiftReg reloads its own contents, which is what keeps
    // rx_data stable in DONE.
    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        ser_out    = 1'b0;
        ser_frame  = 1'b0;
        sr_srl_prl = 1'b0;
        sr_srl_in  = 1'b0;
        sr_prl_in  = sr_prl_out;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;

        case (state)
            IDLE: begin
                tx_ready  = rst_n;
                sr_prl_in = load_word;
                if (tx_valid && rst_n) begin
                    state_next = SHIFT;
                    cnt_clear  = 1'b1;
                end
            end

            SHIFT: begin
                sr_srl_prl = 1'b1;
                sr_srl_in  = ser_in;
                ser_out    = sr_srl_out;
                ser_frame  = 1'b1;
                cnt_inc    = 1'b1;
                if (cnt_tc) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                rx_valid  = 1'b1;
                rx_data   = recv_word;
                sr_prl_in = sr_prl_out;
                if (rx_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule : shift_reg_ctrl

// File: tb/tb_shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_ctrl
//
// Directed bench for shift_reg_ctrl with WIDTH=32. The external ShiftReg is
// modelled here as a plain load/shift register. Honors
// SHIFT_REG_CTRL_LSB_FIRST_EN when the bench is built with it defined.
// -----------------------------------------------------------------------------
module tb_shift_reg_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] rx_data;
    logic         ser_in;
    logic         ser_out;
    logic         ser_frame;
    logic         sr_srl_prl;
    logic         sr_srl_in;
    logic [W-1:0] sr_prl_in;
    logic         sr_srl_out;
    logic [W-1:0] sr_prl_out;

    logic         loopback;
    logic         ser_in_drv;
    logic [W-1:0] sr_q;

    int errors;
    int checks;

    shift_reg_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .sr_srl_prl (sr_srl_prl),
        .sr_srl_in  (sr_srl_in),
        .sr_prl_in  (sr_prl_in),
        .sr_srl_out (sr_srl_out),
        .sr_prl_out (sr_prl_out)
    );

    // External ShiftReg: parallel load or shift left with serial in at LSB.
    always @(posedge clk) begin
        if (sr_srl_prl) begin
            sr_q <= {sr_q[W-2:0], sr_srl_in};
        end else begin
            sr_q <= sr_prl_in;
        end
    end

    assign sr_srl_out = sr_q[W-1];
    assign sr_prl_out = sr_q;
    assign ser_in     = loopback ? ser_out : ser_in_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order in which the bits of a word appear on ser_out.
    function automatic logic [W-1:0] expSerial(input logic [W-1:0] d);
        logic [W-1:0] r;
`ifdef SHIFT_REG_CTRL_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [W-1:0] data, input logic rdy);
        tx_valid = valid;
        tx_data  = data;
        rx_ready = rdy;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Offer one word, wait for it to be accepted, then run until rx_valid.
    // cyc numbers the samples after the accepting edge starting at 1, so the
    // sample following the last of the W shift edges is cycle W+1.
    task automatic sendWord(input logic [W-1:0] data, input logic keep_valid,
                            output int cyc, output logic [W-1:0] bits,
                            output int frames, output int bad);
        applyStimulus(1'b1, data, 1'b0);
        nextCycle();
        if (keep_valid) applyStimulus(1'b1, 32'h1234_5678, 1'b0);
        else            applyStimulus(1'b0, 32'h0, 1'b0);
        cyc    = 1;
        bits   = '0;
        frames = 0;
        bad    = 0;
        while (!rx_valid && cyc < 100) begin
            if (ser_frame) begin
                bits = {bits[W-2:0], ser_out};
                frames++;
            end
            if (tx_ready || rx_valid) bad++;
            nextCycle();
            cyc++;
        end
    endtask

    initial begin
        int           cyc;
        int           frames;
        int           bad;
        logic [W-1:0] bits;

        errors     = 0;
        checks     = 0;
        loopback   = 1'b0;
        ser_in_drv = 1'b0;
        rst_n      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        rx_ready   = 1'b0;

        // Reset values
        nextCycle();
        nextCycle();
        checkOutput("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
        checkOutput("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("rst_ser_out", {31'b0, ser_out}, 32'd0);
        checkOutput("rst_ser_frame", {31'b0, ser_frame}, 32'd0);
        checkOutput("rst_sr_srl_prl", {31'b0, sr_srl_prl}, 32'd0);
        checkOutput("rst_rx_data", rx_data, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_tx_ready", {31'b0, tx_ready}, 32'd1);

        // Loopback of 0x8000_0001
        loopback = 1'b1;
        applyStimulus(1'b1, 32'h8000_0001, 1'b0);
        checkOutput("idle_sr_prl_in", sr_prl_in, expSerial(32'h8000_0001));
        checkOutput("idle_sr_srl_prl", {31'b0, sr_srl_prl}, 32'd0);
        sendWord(32'h8000_0001, 1'b0, cyc, bits, frames, bad);
        checkOutput("lb_latency", cyc, 32'd33);
        checkOutput("lb_serial", bits, expSerial(32'h8000_0001));
        checkOutput("lb_frames", frames, 32'd32);
        checkOutput("lb_shift_flags", bad, 32'd0);
        checkOutput("lb_rx_valid", {31'b0, rx_valid}, 32'd1);
        checkOutput("lb_rx_data", rx_data, 32'h8000_0001);
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        checkOutput("lb_idle_tx_ready", {31'b0, tx_ready}, 32'd1);
        checkOutput("lb_idle_rx_valid", {31'b0, rx_valid}, 32'd0);

        // ser_in held 1, tx_data 0; tx_valid stays high through SHIFT and DONE
        loopback   = 1'b0;
        ser_in_drv = 1'b1;
        sendWord(32'h0000_0000, 1'b1, cyc, bits, frames, bad);
        checkOutput("ones_latency", cyc, 32'd33);
        checkOutput("ones_frames", frames, 32'd32);
        checkOutput("ones_serial", bits, 32'h0000_0000);
        checkOutput("ones_shift_flags", bad, 32'd0);
        checkOutput("ones_rx_data", rx_data, 32'hFFFF_FFFF);

        // Consumer stalls 10 cycles in DONE while tx_valid is offered
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkOutput("stall_rx_data", rx_data, 32'hFFFF_FFFF);
            checkOutput("stall_tx_ready", {31'b0, tx_ready}, 32'd0);
            checkOutput("stall_rx_valid", {31'b0, rx_valid}, 32'd1);
            checkOutput("stall_ser_frame", {31'b0, ser_frame}, 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        checkOutput("stall_idle_tx_ready", {31'b0, tx_ready}, 32'd1);
        checkOutput("stall_idle_rx_valid", {31'b0, rx_valid}, 32'd0);

        // Reset in the middle of SHIFT after 16 shifts
        loopback   = 1'b1;
        ser_in_drv = 1'b0;
        applyStimulus(1'b1, 32'h0F0F_0F0F, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (16) nextCycle();
        checkOutput("mid_ser_frame", {31'b0, ser_frame}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tx_ready", {31'b0, tx_ready}, 32'd0);
        checkOutput("mid_rst_ser_frame", {31'b0, ser_frame}, 32'd0);
        checkOutput("mid_rst_ser_out", {31'b0, ser_out}, 32'd0);
        checkOutput("mid_rst_sr_srl_prl", {31'b0, sr_srl_prl}, 32'd0);
        checkOutput("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("mid_rst_rx_data", rx_data, 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("mid_rst_hold_rx_valid", {31'b0, rx_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_post_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        sendWord(32'hA5A5_A5A5, 1'b0, cyc, bits, frames, bad);
        checkOutput("a5_latency", cyc, 32'd33);
        checkOutput("a5_serial", bits, expSerial(32'hA5A5_A5A5));
        checkOutput("a5_rx_data", rx_data, 32'hA5A5_A5A5);
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();

        // Loopback of 0x0000_0001: first bit out depends on bit order
        sendWord(32'h0000_0001, 1'b0, cyc, bits, frames, bad);
        checkOutput("one_first_bit", {31'b0, bits[W-1]}, {31'b0, expSerial(32'h0000_0001) >> (W-1)});
        checkOutput("one_serial", bits, expSerial(32'h0000_0001));
        checkOutput("one_rx_data", rx_data, 32'h0000_0001);
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        checkOutput("one_idle_tx_ready", {31'b0, tx_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_reg_ctrl
